vga_timing_gen: RTL and testbench

//  Parametrised VGA timing generator with pixel-clock prescaler, blanking mux and pipeline compensation.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_delay_line.sv | 33 +++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types, the 640x480@60 mode constants and the frame-total helper.
package vga_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vga_ctl_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, reset, en};
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator on a single system clock with a pixel-tick prescaler;
// sync/blank are delayed to line up with the pixel source latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FP      = VGA640_H_FP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BP      = VGA640_H_BP,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FP      = VGA640_V_FP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BP      = VGA640_V_BP,
  parameter int CLK_DIV   = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOR_W   = 4,
  parameter int PIPE      = 2,
  localparam int H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               fetch_active,
  output logic               line_start,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic               hsync,
  output logic               vsync,
  output logic               blank_b,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  vga_ctl_t      ctl0;
  vga_ctl_t      ctl_d;

  // Gating with reset keeps the tick quiet while reset is held, even at CLK_DIV=1.
  assign pix_en = (div == DIV_LAST) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
    end else begin
      div <= (div == DIV_LAST) ? '0 : div + DW'(1);
      if (pix_en) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

  assign fetch_active = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign line_start   = pix_en && (x == '0);
  assign frame_start  = pix_en && (x == '0) && (y == '0);

  assign ctl0.hs  = (x >= HS_START) && (x < HS_END);
  assign ctl0.vs  = (y >= VS_START) && (y < VS_END);
  assign ctl0.act = fetch_active;

  vga_delay_line #(
    .WIDTH     ($bits(vga_ctl_t)),
    .DEPTH     (PIPE),
    .RESET_VAL ('0)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .d     (ctl0),
    .q     (ctl_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hsync   <= ~HSYNC_POL;
      vsync   <= ~VSYNC_POL;
      blank_b <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else if (pix_en) begin
      hsync   <= ctl_d.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync   <= ctl_d.vs ? VSYNC_POL : ~VSYNC_POL;
      blank_b <= ctl_d.act;
      r       <= ctl_d.act ? r_in : '0;
      g       <= ctl_d.act ? g_in : '0;
      b       <= ctl_d.act ? b_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen across several modes, dividers, polarities and latencies.
module tb_vga_timing_gen;

  localparam int NCFG = 4;
  localparam int C_HA   [NCFG] = '{16, 16, 640, 16};
  localparam int C_HF   [NCFG] = '{2,  2,  16,  2};
  localparam int C_HS   [NCFG] = '{4,  4,  96,  4};
  localparam int C_HB   [NCFG] = '{3,  3,  48,  3};
  localparam int C_VA   [NCFG] = '{6,  6,  480, 6};
  localparam int C_VF   [NCFG] = '{1,  1,  10,  1};
  localparam int C_VS   [NCFG] = '{2,  2,  2,   2};
  localparam int C_VB   [NCFG] = '{1,  1,  33,  1};
  localparam int C_CD   [NCFG] = '{2,  1,  2,   3};
  localparam int C_HPOL [NCFG] = '{0,  1,  0,   0};
  localparam int C_VPOL [NCFG] = '{0,  0,  0,   1};
  localparam int C_PIPE [NCFG] = '{2,  0,  2,   1};

  typedef struct packed {
    bit       hs;
    bit       vs;
    bit       act;
    bit [3:0] x4;
    bit [3:0] y4;
  } src_t;

  typedef struct packed {
    int x;
    int y;
    bit fa;
    bit ls;
    bit fs;
  } exp_t;

  localparam src_t SRC_IDLE = '{hs: 1'b0, vs: 1'b0, act: 1'b0, x4: 4'hF, y4: 4'hF};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rst_e <= rst;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g
    localparam int HA = C_HA[gi], HF = C_HF[gi], HS = C_HS[gi], HB = C_HB[gi];
    localparam int VA = C_VA[gi], VF = C_VF[gi], VS = C_VS[gi], VB = C_VB[gi];
    localparam int CD = C_CD[gi], PP = C_PIPE[gi];
    localparam bit HPOL = (C_HPOL[gi] != 0);
    localparam bit VPOL = (C_VPOL[gi] != 0);
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam bit [14:0] PINS_RST = {~HPOL, ~VPOL, 1'b0, 12'h000};

    logic          pix_en, fetch_active, line_start, frame_start;
    logic          hsync, vsync, blank_b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    r_in = 4'h0, g_in = 4'h0, b_in = 4'h0;
    logic [3:0]    r, g, b;

    vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(CD), .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
      .COLOR_W(4), .PIPE(PP)
    ) dut (
      .clk(clk), .reset(rst), .pix_en(pix_en), .x(x), .y(y),
      .fetch_active(fetch_active), .line_start(line_start), .frame_start(frame_start),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .hsync(hsync), .vsync(vsync), .blank_b(blank_b), .r(r), .g(g), .b(b)
    );

    function automatic bit [14:0] capture(input src_t d);
      return {d.hs ? HPOL : ~HPOL, d.vs ? VPOL : ~VPOL, d.act,
              d.act ? {d.x4, d.y4, ~d.x4} : 12'h000};
    endfunction

    int        div_m, mx, my;
    bit        tick_prev, exp_pix;
    bit [14:0] pins_vis, pins_next;
    src_t      cur, dly;
    exp_t      e;
    exp_t      expq[$];
    src_t      srcq[$];
    int        blank_cnt;
    bit        frame_seen;

    // Model + pixel source: tracks where the DUT should be, feeds r/g/b_in
    // PIPE ticks after each fetch and queues the expected per-tick outputs.
    always @(posedge clk) begin
      #3;
      if (rst_e) begin
        div_m = 0; mx = 0; my = 0;
        pins_vis = PINS_RST;
        expq.delete();
        srcq.delete();
        for (int i = 0; i < PP; i++) srcq.push_back(SRC_IDLE);
      end else begin
        if (tick_prev) begin
          pins_vis = pins_next;
          if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
          end else begin
            mx = mx + 1;
          end
        end
        div_m = (div_m == CD - 1) ? 0 : div_m + 1;
      end
      exp_pix   = (div_m == CD - 1) && !rst;
      tick_prev = exp_pix;
      if (exp_pix) begin
        cur.hs  = (mx >= HA + HF) && (mx < HA + HF + HS);
        cur.vs  = (my >= VA + VF) && (my < VA + VF + VS);
        cur.act = (mx < HA) && (my < VA);
        cur.x4  = 4'(mx);
        cur.y4  = 4'(my);
        expq.push_back('{x: mx, y: my, fa: cur.act, ls: (mx == 0), fs: (mx == 0 && my == 0)});
        srcq.push_back(cur);
        dly  = srcq.pop_front();
        r_in = dly.x4;
        g_in = dly.y4;
        b_in = ~dly.x4;
        pins_next = capture(dly);
      end
    end

    always @(negedge clk) begin
      checks++;
      if (pix_en !== exp_pix) begin
        failures++;
        $display("FAIL cfg%0d pix_en @%0t: got %b want %b", gi, $time, pix_en, exp_pix);
      end
      checks++;
      if ({hsync, vsync, blank_b, r, g, b} !== pins_vis) begin
        failures++;
        $display("FAIL cfg%0d pins @%0t: got hs=%b vs=%b bb=%b rgb=%h%h%h want %h",
                 gi, $time, hsync, vsync, blank_b, r, g, b, pins_vis);
      end
      if (rst_e) begin
        checks++;
        if (x !== '0 || y !== '0) begin
          failures++;
          $display("FAIL cfg%0d reset_xy @%0t: got x=%0d y=%0d want 0 0", gi, $time, x, y);
        end
      end
      if (pix_en === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL cfg%0d tick @%0t: got unexpected pix_en want none", gi, $time);
        end else begin
          e = expq.pop_front();
          if (x !== XW'(e.x) || y !== YW'(e.y) || fetch_active !== e.fa ||
              line_start !== e.ls || frame_start !== e.fs) begin
            failures++;
            $display("FAIL cfg%0d tick @%0t: got x=%0d y=%0d fa=%b ls=%b fs=%b want x=%0d y=%0d fa=%b ls=%b fs=%b",
                     gi, $time, x, y, fetch_active, line_start, frame_start,
                     e.x, e.y, e.fa, e.ls, e.fs);
          end
          if (e.fs) begin
            if (frame_seen) begin
              checks++;
              if (blank_cnt != HA * VA) begin
                failures++;
                $display("FAIL cfg%0d blank_count @%0t: got %0d want %0d", gi, $time, blank_cnt, HA * VA);
              end
            end
            frame_seen = 1'b1;
            blank_cnt  = 0;
          end
          if (blank_b === 1'b1) blank_cnt++;
        end
      end else begin
        checks++;
        if (line_start !== 1'b0 || frame_start !== 1'b0) begin
          failures++;
          $display("FAIL cfg%0d strobes_idle @%0t: got ls=%b fs=%b want 0 0", gi, $time, line_start, frame_start);
        end
      end
      if (rst) frame_seen = 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    // cfg0 reaches fetch (20,3), inside hsync, on the 191st edge from here.
    repeat (191) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2600) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
